// File: rtl/perceptron_mac_core.sv
// rtl/perceptron_mac_core.sv - sequential multiply-accumulate perceptron with step activation (optional saturation: PERCEPTRON_SAT_EN)
module perceptron_mac_core #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         start_i,
    input  logic [N_INPUTS*DATA_W-1:0]   x_i,
    input  logic [N_INPUTS*DATA_W-1:0]   w_i,
    input  logic signed [DATA_W-1:0]     bias_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic signed [ACC_W-1:0]      acc_o,
    output logic                         y_o,
    output logic                         ovf_o
);

    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]         idx;
    logic                     last_idx;
    logic                     start_accept;

    logic signed [DATA_W-1:0] x_reg [N_INPUTS];
    logic signed [DATA_W-1:0] w_reg [N_INPUTS];

    logic signed [DATA_W-1:0] x_sel;
    logic signed [DATA_W-1:0] w_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;

    assign start_accept = (state == IDLE) && start_i;
    assign last_idx     = (idx == IDX_W'(N_INPUTS - 1));
    assign bias_ext     = {{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i};

    // State register: reset aborts any job in flight
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE -> MAC on accepted start, MAC for N_INPUTS edges, one ACT edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i)  state_next = MAC;
            MAC:     if (last_idx) state_next = ACT;
            ACT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy covers the MAC and ACT cycles
    always_comb begin
        busy_o = 1'b0;
        if (state != IDLE) begin
            busy_o = 1'b1;
        end
    end

    // Operand capture: inputs are frozen at start so the register file may change them freely
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                x_reg[k] <= '0;
                w_reg[k] <= '0;
            end
        end else if (start_accept) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                x_reg[k] <= x_i[k*DATA_W +: DATA_W];
                w_reg[k] <= w_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Product of the current pair, sign-extended to accumulator width
    always_comb begin
        x_sel    = x_reg[idx];
        w_sel    = w_reg[idx];
        prod     = x_sel * w_sel;
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

`ifdef PERCEPTRON_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] wide_sum;
    logic                  sat_hit;

    // Saturating add: one guard bit detects a carry out of the signed range
    always_comb begin
        wide_sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        sat_hit  = (wide_sum[ACC_W] != wide_sum[ACC_W-1]);
        acc_sum  = wide_sum[ACC_W-1:0];
        if (sat_hit) begin
            acc_sum = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Sticky overflow: cleared by an accepted start, set by any saturating add
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ovf_o <= 1'b0;
        end else if (start_accept) begin
            ovf_o <= 1'b0;
        end else if ((state == MAC) && sat_hit) begin
            ovf_o <= 1'b1;
        end
    end
`else
    // Wrapping add: two's complement modulo 2^ACC_W
    always_comb begin
        acc_sum = acc + prod_ext;
    end

    assign ovf_o = 1'b0;
`endif

    // Accumulator and pair index: bias preload on start, one product per MAC edge
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            acc <= '0;
            idx <= '0;
        end else if (start_accept) begin
            acc <= bias_ext;
            idx <= '0;
        end else if (state == MAC) begin
            acc <= acc_sum;
            idx <= last_idx ? '0 : idx + IDX_W'(1);
        end
    end

    // Result registers: updated only in ACT so software sees the previous result until then
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            done_o <= 1'b0;
            acc_o  <= '0;
            y_o    <= 1'b0;
        end else begin
            done_o <= (state == ACT);
            if (state == ACT) begin
                acc_o <= acc;
                y_o   <= !acc[ACC_W-1] && (acc != '0);
            end
        end
    end

endmodule
